// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Memory-side end of the CPU load/store interface. It accepts one word-aligned
// request at a time, waits WAIT_CYCLES, performs the access on a single
// "execute" edge, and then presents the response until the requester takes it.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  responder is idle and will accept a request
//   req_we     in   1 = store, 0 = load
//   req_be     in   store byte enables, bit i covers data[8i+7:8i]
//   req_addr   in   byte address
//   req_wdata  in   store data
//   rsp_valid  out  response present
//   rsp_ready  in   requester consumes the response
//   rsp_rdata  out  load data, 0 for stores and errors
//   rsp_err    out  request was misaligned or out of range
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          rd_ok_q, rd_ok_d;

    // Captured request; only written on the accept edge so later changes on
    // the request bus are ignored.
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic          execute;
    logic          addr_err;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] word_idx;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_data_q;

    // Upper address bits only take part in the range check; they never alias
    // into the array because an out-of-range access is flagged as an error.
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign word_idx = addr_q[AW+1:2];

    assign wr_en = execute &&  we_q && !addr_err;
    assign rd_en = execute && !we_q && !addr_err;

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_ok_d = rd_ok_q;
        accept  = 1'b0;
        execute = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                // A zero count means this edge is the execute edge, which also
                // covers WAIT_CYCLES = 0 (accept edge followed directly by it).
                if (cnt_q == 4'd0) begin
                    execute = 1'b1;
                    state_d = S_RESP;
                    err_d   = addr_err;
                    rd_ok_d = !we_q && !addr_err;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                    rd_ok_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                err_d   = 1'b0;
                rd_ok_d = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = err_q;
    // The RAM read register is not reset, so it is masked until a successful
    // load has completed; this also gives 0 for stores, errors and reset.
    assign rsp_rdata = rd_ok_q ? rd_data_q : 32'h0;

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
            if (accept) begin
                we_q    <= req_we;
                be_q    <= req_be;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage: byte-write RAM with registered read. Not reset; an asynchronous
    // reset forces the FSM to IDLE, which deasserts wr_en before any pending
    // execute edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[word_idx];
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//
// Two responders are instantiated, one with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0. Request fields are shared; req_valid is steered to the DUT
// selected by 'sel', and the outputs of that DUT are muxed onto the bench's
// observation signals. A word-level memory model predicts every response.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    localparam int  DEPTH = 1024;
    localparam int  AW    = 10;
    localparam time T     = 10;
    // {rsp_valid, rsp_err, req_ready, rsp_rdata} when idle
    localparam logic [34:0] IDLE_POST = 35'h1_0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    bit          sel;

    logic        a_req_ready, b_req_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        a_rsp_err,   b_rsp_err;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [34:0] obs;

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign obs       = {rsp_valid, rsp_err, req_ready, rsp_rdata};

    dm_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(2)) dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && !sel),
        .req_ready (a_req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err)
    );

    dm_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(0)) dut_w0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && sel),
        .req_ready (b_req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory, keyed by DUT and word index.
    logic [31:0] model_mem [int];

    function automatic int wait_of();
        return sel ? 0 : 2;
    endfunction

    function automatic void model_access(input logic we, input logic [3:0] be,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic exp_err, output logic [31:0] exp_rdata,
                                         output bit known);
        longint      word;
        int          key;
        logic [31:0] w;
        word      = longint'(addr) / 4;
        exp_err   = (addr % 4 != 0) || (word >= DEPTH);
        exp_rdata = 32'h0;
        known     = 1'b1;
        if (exp_err) return;
        key   = (sel ? DEPTH : 0) + int'(word);
        known = model_mem.exists(key);
        w     = known ? model_mem[key] : 32'h0;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            if (known || be == 4'hF) model_mem[key] = w;
            known = 1'b1;
        end else begin
            exp_rdata = w;
        end
    endfunction

    // Drives one request from a point away from the rising edge, keeps junk on
    // the request bus (with req_valid high) while the DUT is busy, and returns
    // what was observed. lat counts rising edges from acceptance until
    // rsp_valid is seen; -1 means it never rose.
    task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output logic [34:0] post, output time t_acc);
        int n;
        req_we = we; req_be = be; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        t_acc = $time;
        #1;
        req_we = ~we; req_be = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = -1; rdata = 'x; err = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = c - 1; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        post = obs;
        $display("[TB] txn w%0d we=%0b be=%h addr=%h wdata=%h lat=%0d err=%b rdata=%h",
                 wait_of(), we, be, addr, wdata, lat, err, rdata);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            n_tests++;
            if (obs !== IDLE_POST) begin
                n_fail++;
                $display("FAIL reset_immediate w%0d: got %h expected %h", wait_of(), obs, IDLE_POST);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sel = (s == 1);
                #1;
                n_tests++;
                if (obs !== IDLE_POST) begin
                    n_fail++;
                    $display("FAIL reset_held w%0d: got %h expected %h", wait_of(), obs, IDLE_POST);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            n_tests++;
            if (obs !== IDLE_POST) begin
                n_fail++;
                $display("FAIL reset_release w%0d: got %h expected %h", wait_of(), obs, IDLE_POST);
            end
        end
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta;
        logic xe; logic [31:0] xr; bit kn;
        model_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e, post, ta);
        n_tests++;
        if (lat !== wait_of() + 1) begin
            n_fail++;
            $display("FAIL store_latency w%0d: got %0d expected %0d", wait_of(), lat, wait_of() + 1);
        end
        n_tests++;
        if (e !== xe || rd !== xr) begin
            n_fail++;
            $display("FAIL store_rsp w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
        n_tests++;
        if (post !== IDLE_POST) begin
            n_fail++;
            $display("FAIL store_post w%0d: got %h expected %h", wait_of(), post, IDLE_POST);
        end
        model_access(1'b0, 4'h0, 32'h10, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (lat !== wait_of() + 1 || e !== xe || rd !== xr || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_rsp w%0d: got lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
                     wait_of(), lat, e, rd, wait_of() + 1, xe, xr);
        end
    endtask

    task automatic test_byte_enables();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta;
        logic xe; logic [31:0] xr; bit kn;
        model_access(1'b1, 4'b0101, 32'h10, 32'h11223344, xe, xr, kn);
        do_txn(1'b1, 4'b0101, 32'h10, 32'h11223344, lat, rd, e, post, ta);
        model_access(1'b1, 4'b0000, 32'h10, 32'h55667788, xe, xr, kn);
        do_txn(1'b1, 4'b0000, 32'h10, 32'h55667788, lat, rd, e, post, ta);
        n_tests++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL be_zero_err w%0d: got %b expected 0", wait_of(), e);
        end
        model_access(1'b0, 4'h0, 32'h10, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (rd !== xr || e !== xe) begin
            n_fail++;
            $display("FAIL byte_enable w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta;
        logic xe; logic [31:0] xr; bit kn;
        logic [31:0] v;
        v = $urandom;
        model_access(1'b1, 4'hF, 32'h0, v, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'h0, v, lat, rd, e, post, ta);
        v = $urandom;
        model_access(1'b1, 4'hF, 32'(4 * (DEPTH - 1)), v, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'(4 * (DEPTH - 1)), v, lat, rd, e, post, ta);
        model_access(1'b0, 4'h0, 32'h12, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h12, 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (e !== xe || rd !== xr || lat !== wait_of() + 1) begin
            n_fail++;
            $display("FAIL misaligned_load w%0d: got err=%b rdata=%h lat=%0d expected err=%b rdata=%h", wait_of(), e, rd, lat, xe, xr);
        end
        n_tests++;
        if (post !== IDLE_POST) begin
            n_fail++;
            $display("FAIL error_post w%0d: got %h expected %h", wait_of(), post, IDLE_POST);
        end
        model_access(1'b1, 4'hF, 32'(4 * DEPTH), 32'hA5A5A5A5, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'(4 * DEPTH), 32'hA5A5A5A5, lat, rd, e, post, ta);
        n_tests++;
        if (e !== xe || rd !== xr) begin
            n_fail++;
            $display("FAIL range_store w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
        model_access(1'b0, 4'h0, 32'h0, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h0, 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (e !== xe || rd !== xr) begin
            n_fail++;
            $display("FAIL word0_intact w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
        model_access(1'b0, 4'h0, 32'(4 * (DEPTH - 1)), 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'(4 * (DEPTH - 1)), 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (e !== xe || rd !== xr) begin
            n_fail++;
            $display("FAIL wordlast_intact w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta;
        logic xe; logic [31:0] xr; bit kn; bit seen;
        logic [31:0] v;
        v = $urandom;
        model_access(1'b1, 4'hF, 32'h40, v, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'h40, v, lat, rd, e, post, ta);
        rsp_ready = 1'b0;
        req_we = 1'b0; req_be = 4'hF; req_addr = 32'h40; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Competing store to the same word; it must never be accepted.
        req_we = 1'b1; req_wdata = ~v;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_rsp_timeout w%0d: got rsp_valid=%b expected 1", wait_of(), rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== {1'b1, 1'b0, 1'b0, v}) begin
                n_fail++;
                $display("FAIL bp_hold w%0d cycle %0d: got %h expected %h", wait_of(), k, obs, {1'b1, 1'b0, 1'b0, v});
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs !== IDLE_POST) begin
            n_fail++;
            $display("FAIL bp_release w%0d: got %h expected %h", wait_of(), obs, IDLE_POST);
        end
        model_access(1'b0, 4'h0, 32'h40, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h40, 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (rd !== xr || e !== xe) begin
            n_fail++;
            $display("FAIL bp_no_queue w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
    endtask

    task automatic test_mid_reset();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta;
        logic xe; logic [31:0] xr; bit kn; int seen;
        logic [31:0] prior;
        prior = $urandom;
        model_access(1'b1, 4'hF, 32'h20, prior, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'h20, prior, lat, rd, e, post, ta);
        // Aborted store: the model is deliberately not updated.
        req_we = 1'b1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (obs !== IDLE_POST) begin
            n_fail++;
            $display("FAIL midrst_async w%0d: got %h expected %h", wait_of(), obs, IDLE_POST);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_rsp w%0d: got %0d response cycles expected 0", wait_of(), seen);
        end
        model_access(1'b0, 4'h0, 32'h20, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, e, post, ta);
        n_tests++;
        if (rd !== xr || rd !== prior || e !== 1'b0 || lat !== wait_of() + 1) begin
            n_fail++;
            $display("FAIL midrst_mem w%0d: got rdata=%h err=%b lat=%0d expected rdata=%h err=0 lat=%0d",
                     wait_of(), rd, e, lat, prior, wait_of() + 1);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta0, ta1;
        logic xe; logic [31:0] xr; bit kn;
        logic [31:0] v;
        v = $urandom;
        model_access(1'b1, 4'hF, 32'h80, v, xe, xr, kn);
        do_txn(1'b1, 4'hF, 32'h80, v, lat, rd, e, post, ta0);
        model_access(1'b0, 4'h0, 32'h80, 32'h0, xe, xr, kn);
        do_txn(1'b0, 4'h0, 32'h80, 32'h0, lat, rd, e, post, ta1);
        n_tests++;
        if (ta1 - ta0 !== T * (wait_of() + 3)) begin
            n_fail++;
            $display("FAIL b2b_spacing w%0d: got %0t expected %0t", wait_of(), ta1 - ta0, T * (wait_of() + 3));
        end
        n_tests++;
        if (rd !== xr || e !== xe) begin
            n_fail++;
            $display("FAIL b2b_raw w%0d: got err=%b rdata=%h expected err=%b rdata=%h", wait_of(), e, rd, xe, xr);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic e; logic [34:0] post; time ta;
        logic xe; logic [31:0] xr; bit kn;
        int pool [8];
        int idx, kind;
        logic we; logic [3:0] be; logic [31:0] addr, wd;
        for (int i = 0; i < 8; i++) begin
            pool[i] = (i == 0) ? 0 : (i == 1) ? DEPTH - 1 : int'($urandom_range(2, DEPTH - 2));
            wd = $urandom;
            model_access(1'b1, 4'hF, 32'(pool[i] * 4), wd, xe, xr, kn);
            do_txn(1'b1, 4'hF, 32'(pool[i] * 4), wd, lat, rd, e, post, ta);
        end
        for (int t = 0; t < 30; t++) begin
            idx  = pool[$urandom_range(0, 7)];
            kind = int'($urandom_range(0, 5));
            we   = 1'($urandom);
            be   = 4'($urandom);
            wd   = $urandom;
            if (kind == 0)
                addr = 32'(idx * 4) + 32'($urandom_range(1, 3));
            else if (kind == 1)
                addr = (32'($urandom_range(1, (1 << (30 - AW)) - 1)) << (AW + 2)) | 32'(idx * 4);
            else
                addr = 32'(idx * 4);
            model_access(we, be, addr, wd, xe, xr, kn);
            do_txn(we, be, addr, wd, lat, rd, e, post, ta);
            n_tests++;
            if (lat !== wait_of() + 1) begin
                n_fail++;
                $display("FAIL rand_latency w%0d #%0d: got %0d expected %0d", wait_of(), t, lat, wait_of() + 1);
            end
            n_tests++;
            if (e !== xe || (kn && rd !== xr)) begin
                n_fail++;
                $display("FAIL rand_rsp w%0d #%0d addr=%h: got err=%b rdata=%h expected err=%b rdata=%h",
                         wait_of(), t, addr, e, rd, xe, xr);
            end
            n_tests++;
            if (post !== IDLE_POST) begin
                n_fail++;
                $display("FAIL rand_post w%0d #%0d: got %h expected %h", wait_of(), t, post, IDLE_POST);
            end
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1; sel = 1'b0;
        test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            @(negedge clk);
            test_store_load();
            test_byte_enables();
            test_errors();
            test_backpressure();
            test_mid_reset();
            test_back_to_back();
            test_random();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d tests run expected completion", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder: the memory-side end of the load/store interface the CPU datapath drives. It accepts one word-aligned read or write request at a time over a valid/ready handshake, and inserts a programmable number of wait states. It applies per-byte write enables, then returns read data or a write acknowledge, with an error flag, over a second valid/ready handshake. It replaces the zero-latency data memory when the team moves to a stall-capable core.

Parameters:
DEPTH, 1024, number of 32-bit words stored; must be a power of two.
AW, 10, word-index width, log2(DEPTH).
WAIT_CYCLES, 2, wait states between request acceptance and the response (0..15).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_be  input  4  byte enables for a store; bit i covers data bits [8i+7:8i].
req_addr  input  32  byte address.
req_wdata  input  32  store data.
rsp_valid  output  1  response present.
rsp_ready  input  1  requester consumes the response.
rsp_rdata  output  32  load data; 0 for stores and for errors.
rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst low, asynchronous): state is IDLE, wait counter is 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not reset.
- State machine has three states: IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - When req_valid&&req_ready is sampled, capture we, be, addr and wdata.
  - Go to WAIT with the counter at WAIT_CYCLES. If WAIT_CYCLES=0, go directly to the execute edge described under WAIT.
- WAIT:
  - req_ready=0. The counter decrements each cycle.
  - When the counter reaches 0, the next edge is the execute edge. On that edge the access is performed and the state moves to RESP.
- Execute edge:
  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH).
  - Store without error: write only the enabled bytes of word addr[AW+1:2]. be=4'b0000 changes nothing and is not an error.
  - Load without error: rsp_rdata = mem[addr[AW+1:2]].
  - Error: no memory change, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready is sampled.
  - On that edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, and the state returns to IDLE.
  - A new request cannot be accepted in the same cycle as the response handoff (req_ready=0 in RESP).
- Latency: a request accepted at edge N gives rsp_valid high after edge N+WAIT_CYCLES+1. Throughput is at most one request per WAIT_CYCLES+3 cycles.
- The requester must hold the request fields only until acceptance; changes afterwards are ignored.
- req_valid while not in IDLE is ignored and not queued.
- rsp_ready may stay high continuously, giving a one-cycle rsp_valid pulse. If rsp_ready is low, the response is held indefinitely.
- Read-after-write: a load issued after a store's response returns the new data.
- Reset asserted mid-operation aborts the transaction:
  - A store whose execute edge has not occurred leaves memory unchanged.
  - Any pending response is dropped.
- Only bits [AW+1:2] index the memory. Bits [31:AW+2] are used only for the range check.

Test Plan:
- Reset then idle: rst low for 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 immediately and during reset.
- Store/load with WAIT_CYCLES=2: store addr 0x10, be=4'hF, wdata 0xDEADBEEF, rsp_ready=1 -> rsp_valid 3 cycles after acceptance with rsp_err=0 and rsp_rdata=0. Load 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte enables: after the above, store 0x10 with be=4'b0101, wdata 0x11223344. Load 0x10 -> 0xDE22BE44.
- Errors: load 0x12 -> rsp_err=1, rsp_rdata=0. Store to 4*DEPTH -> rsp_err=1, and word 0 and word DEPTH-1 are unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and data remain stable. A second req_valid during this time is not accepted (req_ready=0). Raise rsp_ready -> back to IDLE one cycle later.
- Mid-operation reset: accept store 0x20 = 0xCAFEF00D, pulse rst low during WAIT -> no response, and a subsequent load of 0x20 returns the prior value. Repeat the full sequence with WAIT_CYCLES=0 -> response 1 cycle after acceptance.
